hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use and branch hazards, freezes the pipe on data-memory wait states, and produces the EX-stage operand forwarding selects. It sits beside the pipeline registers and contains no datapath.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/forward_unit.sv | 22 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_t  - sequencing FSM states (RUN, MEM_WAIT, HALT)
//   FWD_*       - EX operand source selects
//   WAIT_CNT_W  - width of the data-memory wait counter
//   fwd_sel()   - one-operand forwarding decision, MEM beats WB, x0 never forwarded
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int WAIT_CNT_W = 8;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_reg_write,
    input logic [4:0] wb_rd,
    input logic       wb_reg_write
  );
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) return FWD_MEM;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))    return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational EX-stage operand forwarding selects.
//   ex_rs1, ex_rs2           - EX source registers
//   mem_rd, mem_reg_write    - MEM stage destination / write flag
//   wb_rd, wb_reg_write      - WB stage destination / write flag
//   fwd_a, fwd_b             - operand source (FWD_NONE / FWD_WB / FWD_MEM)
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Drives PC / pipeline register enables and flushes, resolves load-use and
// branch hazards, freezes the pipe on dmem wait states and halts on timeout.
//
// Build option: HAZARD_FWD_EN
//   defined   - forward_unit drives fwd_a/fwd_b; only load-use stalls decode.
//   undefined - fwd_a/fwd_b tied to 00; any RAW on EX or MEM stalls decode.
//
// Ports:
//   clk, rst (async, active-high)
//   id_*        - decode sources and use flags
//   ex_*        - EX sources, destination, write/load flags, branch taken
//   mem_*, wb_* - MEM / WB destination and write flags
//   dmem_req, dmem_ready - data memory handshake
//   pc_en, ifid_en, idex_en, exmem_en - register load enables
//   ifid_flush, idex_flush, memwb_flush - bubble inserts
//   fwd_a, fwd_b - EX operand selects
//   halted       - memory timeout; frozen until reset
//
// state    | meaning
// RUN      | normal operation
// MEM_WAIT | data memory stall in progress, wait_cnt counts stalled cycles
// HALT     | memory timeout, terminal until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       memwb_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted
);

  hz_state_t             state, state_n;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic                  mem_stall;
  logic                  data_hazard;
  logic [1:0]            fwd_a_raw, fwd_b_raw;

  assign mem_stall = dmem_req && !dmem_ready;

`ifdef HAZARD_FWD_EN
  // Only a load result is too late to forward into the next instruction.
  assign data_hazard = ex_is_load && ex_reg_write && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

  forward_unit u_forward_unit (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );
`else
  logic ex_raw, mem_raw;
  logic unused_inputs;

  // WB is excluded: the register file writes in the first half cycle.
  assign ex_raw  = ex_reg_write && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_raw = mem_reg_write && (mem_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == mem_rd)) ||
                    (id_use_rs2 && (id_rs2 == mem_rd)));
  assign data_hazard = ex_raw || mem_raw;

  assign fwd_a_raw = FWD_NONE;
  assign fwd_b_raw = FWD_NONE;
  assign unused_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_write, ex_is_load};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      halted   <= (state_n == HALT);
    end
  end

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_stall) begin
            memwb_flush = 1'b1;
            if (state == RUN) begin
              state_n    = MEM_WAIT;
              wait_cnt_n = WAIT_CNT_W'(1);
            end else if (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT)) begin
              state_n = HALT;
            end else begin
              wait_cnt_n = wait_cnt + 1'b1;
            end
          end else begin
            state_n    = RUN;
            wait_cnt_n = '0;
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            // A taken branch kills the decode instruction, so its hazard is moot.
            if (ex_branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (data_hazard) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
        HALT: ;
        default: state_n = RUN;
      endcase
    end
  end

  assign fwd_a = (rst || state == HALT) ? FWD_NONE : fwd_a_raw;
  assign fwd_b = (rst || state == HALT) ? FWD_NONE : fwd_b_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector bench for hazard_ctrl (MEM_TIMEOUT = 4).
// Expectations adapt to whether HAZARD_FWD_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b}
  localparam logic [10:0] E_RUN   = 11'b1111_000_00_00;
  localparam logic [10:0] E_STALL = 11'b0011_010_00_00;
  localparam logic [10:0] E_BR    = 11'b1111_110_00_00;
  localparam logic [10:0] E_MW    = 11'b0000_001_00_00;
  localparam logic [10:0] E_ZERO  = 11'b0000_000_00_00;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load;
  logic       mem_reg_write, wb_reg_write, ex_branch_taken, dmem_req, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, memwb_flush, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [10:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en,
                 ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .ex_rs1 (ex_rs1), .ex_rs2 (ex_rs2), .ex_rd (ex_rd),
    .ex_reg_write (ex_reg_write), .ex_is_load (ex_is_load),
    .mem_rd (mem_rd), .mem_reg_write (mem_reg_write),
    .wb_rd (wb_rd), .wb_reg_write (wb_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req (dmem_req), .dmem_ready (dmem_ready),
    .pc_en (pc_en), .ifid_en (ifid_en), .idex_en (idex_en), .exmem_en (exmem_en),
    .ifid_flush (ifid_flush), .idex_flush (idex_flush), .memwb_flush (memwb_flush),
    .fwd_a (fwd_a), .fwd_b (fwd_b), .halted (halted)
  );

  typedef struct {
    logic [4:0]  id_rs1, id_rs2;
    logic        use1, use2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_we, ex_ld;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [4:0]  wb_rd;
    logic        wb_we, br;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(
    input logic [4:0] i1, input logic [4:0] i2, input logic u1, input logic u2,
    input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] erd,
    input logic ewe, input logic eld, input logic [4:0] mrd, input logic mwe,
    input logic [4:0] wrd, input logic wwe, input logic br, input logic [10:0] exp);
    vec_t v;
    v.id_rs1 = i1; v.id_rs2 = i2; v.use1 = u1; v.use2 = u2;
    v.ex_rs1 = e1; v.ex_rs2 = e2; v.ex_rd = erd; v.ex_we = ewe; v.ex_ld = eld;
    v.mem_rd = mrd; v.mem_we = mwe; v.wb_rd = wrd; v.wb_we = wwe; v.br = br;
    v.exp = exp;
    return v;
  endfunction

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_is_load = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
    ex_reg_write = v.ex_we; ex_is_load = v.ex_ld;
    mem_rd = v.mem_rd; mem_reg_write = v.mem_we;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_we; ex_branch_taken = v.br;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    //         id1 id2 u1 u2 ex1 ex2 erd ewe eld mrd mwe wrd wwe br  expected
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
    vecs[1]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, E_STALL);
    vecs[2]  = mk(0, 5, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, E_RUN);
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, E_RUN);
    vecs[4]  = mk(6, 0, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, FWD ? E_RUN : E_STALL);
    vecs[5]  = mk(0, 0, 0, 0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, E_RUN | (FWD ? 11'b0010 : 11'b0));
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_RUN);
    vecs[7]  = mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 9, 1, 0, E_RUN | (FWD ? 11'b0100 : 11'b0));
    vecs[8]  = mk(0, 0, 0, 0, 4, 8, 0, 0, 0, 4, 1, 8, 1, 0, E_RUN | (FWD ? 11'b1001 : 11'b0));
    vecs[9]  = mk(0, 0, 0, 0, 4, 0, 0, 0, 0, 4, 0, 4, 1, 0, E_RUN | (FWD ? 11'b0100 : 11'b0));
    vecs[10] = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, E_BR);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_BR);
    vecs[12] = mk(0, 3, 0, 1, 0, 3, 0, 0, 0, 3, 1, 0, 0, 0,
                  FWD ? (E_RUN | 11'b0010) : E_STALL);
    vecs[13] = mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, E_RUN);

    set_idle();
    rst = 1'b1;
    #3;
    chk("reset_outs", outs, E_ZERO);
    chk("reset_halted", {10'b0, halted}, 11'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_idle", outs, E_RUN);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // load-use: one stall cycle, then load in MEM, then consumer in EX
    @(negedge clk);
    set_idle();
    id_rs1 = 5; id_use_rs1 = 1; ex_rd = 5; ex_reg_write = 1; ex_is_load = 1;
    #1 chk("lu_stall", outs, E_STALL);
    @(negedge clk);
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; mem_rd = 5; mem_reg_write = 1;
    #1 chk("lu_release", outs, FWD ? E_RUN : E_STALL);
    @(negedge clk);
    set_idle();
    ex_rs1 = 5; wb_rd = 5; wb_reg_write = 1;
    #1 chk("lu_consume", outs, E_RUN | (FWD ? 11'b0100 : 11'b0));

    // memory wait of three cycles, branch held in EX during the last one
    @(negedge clk);
    set_idle();
    dmem_req = 1; dmem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 2) ex_branch_taken = 1;
      #1 chk($sformatf("mem_wait%0d", k), outs, E_MW);
    end
    @(negedge clk);
    dmem_ready = 1;
    #1 chk("mem_release_branch", outs, E_BR);
    @(negedge clk);
    set_idle();
    #1 chk("mem_after_release", outs, E_RUN);
    chk("mem_no_halt", {10'b0, halted}, 11'b0);
    dmem_req = 1; dmem_ready = 1;
    #1 chk("req_ready_same_cycle", outs, E_RUN);

    // timeout: fifth stalled cycle moves to HALT
    @(negedge clk);
    set_idle();
    dmem_req = 1;
    #1 chk("to_stall0", outs, E_MW);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("to_halted%0d", k), {10'b0, halted}, (k == 5) ? 11'b1 : 11'b0);
    end
    chk("halt_outs", outs, E_ZERO);
    dmem_ready = 1; ex_branch_taken = 1; mem_rd = 2; mem_reg_write = 1; ex_rs1 = 2;
    #1 chk("halt_ignores_inputs", outs, E_ZERO);
    @(negedge clk);
    #1 chk("halt_sticky", {10'b0, halted}, 11'b1);
    #1 rst = 1'b1;
    #1 chk("halt_async_reset", {10'b0, halted}, 11'b0);
    chk("halt_reset_outs", outs, E_ZERO);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1 chk("after_reset_run", outs, E_RUN);

    // stall count restarts after reset: four stalled cycles stay out of HALT
    dmem_req = 1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    #1 chk("restart_no_halt", {10'b0, halted}, 11'b0);
    chk("restart_stalling", outs, E_MW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
